// File: rtl/wildcard_lane_selector.sv
`default_nettype none
// ============================================================================
// Module      : wildcard_lane_selector
// Description : Picks one LANE_W-bit lane out of a wide bus. The lane comes
//               from a programmable table of wildcard rules (value/care mask)
//               checked in priority order, with rule 0 highest. The selector
//               is taken from an external valid/ready stream or from an
//               internal auto-incrementing counter. The result is registered
//               behind an output valid/ready handshake, and selectors that hit
//               no rule are counted in a saturating miss counter.
// Revision    : 1.0 - initial release
// ============================================================================
module wildcard_lane_selector #(
  parameter int LANE_W       = 8,
  parameter int NUM_LANES    = 16,
  parameter int SEL_W        = 4,
  parameter int NUM_RULES    = 4,
  parameter int DEFAULT_LANE = 15,
  localparam int LIDX_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int RIDX_W      = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LANE_W*NUM_LANES-1:0]   wide_input_bus,
  input  logic                          mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SEL_W-1:0]              selector,
  input  logic                          cfg_we,
  input  logic [RIDX_W-1:0]             cfg_idx,
  input  logic                          cfg_en,
  input  logic [SEL_W-1:0]              cfg_value,
  input  logic [SEL_W-1:0]              cfg_care,
  input  logic [LIDX_W-1:0]             cfg_lane,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANE_W-1:0]             selected_out,
  output logic                          out_hit,
  output logic [RIDX_W-1:0]             out_rule,
  output logic [SEL_W-1:0]              out_sel,
  output logic [15:0]                   miss_cnt
);

  // Per-rule match flags and lane fields gathered from the rule slices.
  logic [NUM_RULES-1:0]             match;
  logic [NUM_RULES-1:0][LIDX_W-1:0] rule_lane;

  logic [SEL_W-1:0]  auto_cnt;
  logic [SEL_W-1:0]  cur_sel;
  logic              accept;

  logic              win_hit;
  logic [RIDX_W-1:0] win_rule;
  logic [LIDX_W-1:0] win_lane;
  logic [LIDX_W-1:0] eff_lane;
  logic [LANE_W-1:0] lane_data;

  // Selector source: the internal counter in auto mode, the external port otherwise.
  assign cur_sel  = mode ? auto_cnt : selector;

  // A new selector may enter whenever the output slot is empty or being drained.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_ready && (mode || in_valid);

  // One storage slice per rule. Each slice only responds to its own index,
  // so a write to one rule can never disturb another. The match is computed
  // from the registered table, which means a write in the same cycle as an
  // accept is not seen by that accept.
  generate
    for (genvar r = 0; r < NUM_RULES; r++) begin : g_rule
      logic              en_q;
      logic [SEL_W-1:0]  value_q;
      logic [SEL_W-1:0]  care_q;
      logic [LIDX_W-1:0] lane_q;

      // Rule storage: loaded by a config strobe addressed to this index.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          en_q    <= 1'b0;
          value_q <= '0;
          care_q  <= '0;
          lane_q  <= '0;
        end else if (cfg_we && (cfg_idx == RIDX_W'(r))) begin
          en_q    <= cfg_en;
          value_q <= cfg_value;
          care_q  <= cfg_care;
          lane_q  <= cfg_lane;
        end
      end

      // Care bits set to 0 act as "don't care" wildcards.
      assign match[r]     = en_q && (((cur_sel ^ value_q) & care_q) == '0);
      assign rule_lane[r] = lane_q;
    end
  endgenerate

  // Priority resolve: scan from the lowest priority upwards so the
  // lowest-indexed matching rule is the last one written and wins.
  always_comb begin
    win_hit  = 1'b0;
    win_rule = '0;
    win_lane = '0;
    for (int r = NUM_RULES - 1; r >= 0; r--) begin
      if (match[r]) begin
        win_hit  = 1'b1;
        win_rule = RIDX_W'(r);
        win_lane = rule_lane[r];
      end
    end
  end

  // Lane choice: a miss or an out-of-range lane index falls back to the
  // default lane. An out-of-range index still counts as a hit.
  always_comb begin
    eff_lane = LIDX_W'(DEFAULT_LANE);
    if (win_hit && (32'(win_lane) < NUM_LANES)) begin
      eff_lane = win_lane;
    end
  end

  // Lane multiplexer over the wide bus.
  always_comb begin
    lane_data = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (eff_lane == LIDX_W'(k)) begin
        lane_data = wide_input_bus[k*LANE_W +: LANE_W];
      end
    end
  end

  // Output slot: capture on accept, hold under backpressure, empty on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      selected_out <= '0;
      out_hit      <= 1'b0;
      out_rule     <= '0;
      out_sel      <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      selected_out <= lane_data;
      out_hit      <= win_hit;
      out_rule     <= win_rule;
      out_sel      <= cur_sel;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  // Auto selector counter: advances only on accepts made in auto mode, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_cnt <= '0;
    end else if (accept && mode) begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end

  // Miss statistics: count accepted selectors that hit no rule, saturating at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cnt <= '0;
    end else if (accept && !win_hit && (miss_cnt != 16'hFFFF)) begin
      miss_cnt <= miss_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: doc/wildcard_lane_selector.md
Name: wildcard_lane_selector

Overview:
Parametrised, programmable successor to the fixed inside/priority-casez byte-lane selector.
- Picks one LANE_W-bit lane from a wide input bus using a table of NUM_RULES wildcard rules (value/care mask), evaluated in priority order.
- Selector comes from an external valid/ready stream or an internal auto-incrementing counter.
- Result is registered with an output handshake; miss statistics are kept.
- Sits between bus-steering testbench stimulus and downstream checkers in the SV feature regression designs.

Parameters:
LANE_W, 8, width of one lane in bits
NUM_LANES, 16, number of lanes on wide_input_bus
SEL_W, 4, selector width in bits
NUM_RULES, 4, number of wildcard rules; index 0 has highest priority
DEFAULT_LANE, 15, lane used when no enabled rule matches
(derived) LIDX_W = $clog2(NUM_LANES), RIDX_W = $clog2(NUM_RULES), minimum 1 each

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
wide_input_bus  in  LANE_W*NUM_LANES  lane k = bits [k*LANE_W +: LANE_W]
mode  in  1  0 = external selector, 1 = auto-count
in_valid  in  1  external selector valid (ignored when mode=1)
in_ready  out  1  block can accept a selector this cycle
selector  in  SEL_W  external selector value
cfg_we  in  1  rule table write strobe
cfg_idx  in  RIDX_W  rule index to write
cfg_en  in  1  rule enable
cfg_value  in  SEL_W  rule compare value
cfg_care  in  SEL_W  1 = compare bit, 0 = wildcard
cfg_lane  in  LIDX_W  lane selected on match
out_valid  out  1  registered result valid
out_ready  in  1  downstream accepts result
selected_out  out  LANE_W  selected lane data
out_hit  out  1  1 = a rule matched, 0 = default lane used
out_rule  out  RIDX_W  index of winning rule; 0 when out_hit=0
out_sel  out  SEL_W  selector that produced this result
miss_cnt  out  16  count of accepted selectors that hit no rule; saturating

Behaviour:
- Reset (async assert, released synchronously to clk):
  - all rules disabled, value/care/lane = 0
  - out_valid=0, selected_out=0, out_hit=0, out_rule=0, out_sel=0, miss_cnt=0
  - auto counter = 0
- Rule match: rule r matches when en[r] && ((sel ^ value[r]) & care[r]) == 0.
  - Lowest-indexed matching rule wins.
  - care=0 on a bit matches both 0 and 1 (casez "?" semantics). An enabled rule with care all zero matches everything.
- Lane select:
  - lane = winning rule's lane, else DEFAULT_LANE.
  - A lane index >= NUM_LANES (non-power-of-2 NUM_LANES) selects DEFAULT_LANE; out_hit stays 1.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Accept = in_ready && (mode ? 1 : in_valid).
  - On accept, the next cycle has out_valid=1 with selected_out/out_hit/out_rule/out_sel computed from the current-cycle selector, table and wide_input_bus. Latency is 1 cycle.
  - Result holds stable while out_valid && !out_ready. Full throughput with out_ready held high.
  - If out_ready=1 and there is no accept, out_valid drops to 0.
- Auto mode:
  - Selector = internal counter; it increments by 1 per accept and wraps 2^SEL_W-1 -> 0.
  - The counter holds when mode=0.
  - Switching mode takes effect on the next accept; the counter is not cleared.
- Config writes:
  - Rule writes may occur any cycle, including during stall.
  - A write in the same cycle as an accept does not affect that accept; it uses the pre-write table.
  - Writing one rule never alters other rules.
- miss_cnt: +1 per accept with no match; saturates at 16'hFFFF.
- Reset mid-transfer: output is dropped immediately (out_valid=0); the table is lost.

Test Plan:
- Setup: bus lanes 0..15 = a0,a1,a2,a3,a4,a5,a6,a7,85,95,a5,b5,c5,d5,ef,f5. Rules:
  - r0 = value 0000 / care 0110 / lane 0
  - r1 = 1100 / 1111 / lane 0
  - r2 = 0010 / 1011 / lane 1
  - r3 = 0000 / 1001 / lane 2
  - all enabled, mode=1, out_ready=1
- Sweep selectors 0..15:
  - 0,1,8,9,12 -> a0 (hit=1)
  - 2,6 -> a1, rule 2
  - 4 -> a2, rule 3
  - 3,5,7,10,11,13,14,15 -> f5 (hit=0)
  - After one pass, miss_cnt=8. Counter wraps 15 -> 0, after which 0 -> a0 again.
- Priority: selector 0000 matches r0 and r3 -> out_rule=0, a0. Disable r0 -> selector 0000 gives out_rule=3, a2.
- Backpressure: mode=0, in_valid=1, out_ready=0 for 3 cycles -> in_ready=0, outputs frozen. Raise out_ready -> next result appears the following cycle, and no selector is lost or duplicated.
- Same-cycle write: accept selector 0100 while rewriting r3 lane to 5 -> result a2. Next 0100 -> a5.
- Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, miss_cnt=0 immediately. After release, all selectors give f5 with hit=0.
